// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage
// Instruction fetch stage: captures the next pstate pair from the address
// stage, issues one instruction-cache request per aligned address, and holds
// the fetched word (or a trap code) for the operand-fetch stage.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   inPstate0, inPstate1         next segment/status word and instruction offset
//   inStall                      downstream cannot consume this cycle
//   inFlush                      discard in-flight fetch (redirect)
//   outAdrReady                  combinational: pstate captured at this edge
//   outIcReq/outIcSeg/outIcOfs   instruction cache request
//   inIcAck/inIcErr/inIcData     instruction cache response
//   outFdValid                   fetched instruction/pstate valid downstream
//   outFdPstate0/outFdPstate1    pstate of the fetched instruction
//   outFdInstr                   fetched word, 0 when a trap code is set
//   outFdTrap                    0 none, 1 cache error, 2 misaligned, 3 timeout
module instr_fetch_stage #(
    parameter int unsigned WORD_LENGTH   = 32,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LENGTH-1:0] inPstate0,
    input  logic [WORD_LENGTH-1:0] inPstate1,
    input  logic                   inStall,
    input  logic                   inFlush,
    output logic                   outAdrReady,
    output logic                   outIcReq,
    output logic [15:0]            outIcSeg,
    output logic [WORD_LENGTH-1:0] outIcOfs,
    input  logic                   inIcAck,
    input  logic                   inIcErr,
    input  logic [WORD_LENGTH-1:0] inIcData,
    output logic                   outFdValid,
    output logic [WORD_LENGTH-1:0] outFdPstate0,
    output logic [WORD_LENGTH-1:0] outFdPstate1,
    output logic [WORD_LENGTH-1:0] outFdInstr,
    output logic [1:0]             outFdTrap
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_CACHE   = 2'd1;
    localparam logic [1:0] TRAP_ALIGN   = 2'd2;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd3;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(FETCH_TIMEOUT);

    logic [1:0]             state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [WORD_LENGTH-1:0] pstate0_q, pstate0_d;
    logic [WORD_LENGTH-1:0] pstate1_q, pstate1_d;
    logic [WORD_LENGTH-1:0] instr_q,   instr_d;
    logic [1:0]             trap_q,    trap_d;
    logic                   adr_ready;

    // Address handshake: open in IDLE, or in VALID when the word is consumed.
    always_comb begin
        adr_ready = 1'b0;
        if (!rst && !inFlush) begin
            adr_ready = (state_q == IDLE) || ((state_q == VALID) && !inStall);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pstate0_d = pstate0_q;
        pstate1_d = pstate1_q;
        instr_d   = instr_q;
        trap_d    = trap_q;

        if (inFlush) begin
            // Redirect wins over any response or timeout this cycle.
            state_d = IDLE;
        end else if (adr_ready) begin
            pstate0_d = inPstate0;
            pstate1_d = inPstate1;
            cnt_d     = '0;
            instr_d   = '0;
            if (inPstate1[1:0] != 2'b00) begin
                // Misaligned offset never reaches the cache.
                state_d = VALID;
                trap_d  = TRAP_ALIGN;
            end else begin
                state_d = FETCH;
                trap_d  = TRAP_NONE;
            end
        end else if (state_q == FETCH) begin
            if (inIcAck) begin
                state_d = VALID;
                if (inIcErr) begin
                    instr_d = '0;
                    trap_d  = TRAP_CACHE;
                end else begin
                    instr_d = inIcData;
                    trap_d  = TRAP_NONE;
                end
            end else if (cnt_q == TIMEOUT_CNT) begin
                state_d = VALID;
                instr_d = '0;
                trap_d  = TRAP_TIMEOUT;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (state_q != IDLE && state_q != VALID) begin
            // Unused encoding recovers to IDLE.
            state_d = IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pstate0_q <= '0;
            pstate1_q <= '0;
            instr_q   <= '0;
            trap_q    <= TRAP_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pstate0_q <= pstate0_d;
            pstate1_q <= pstate1_d;
            instr_q   <= instr_d;
            trap_q    <= trap_d;
        end
    end

    assign outAdrReady  = adr_ready;
    assign outIcReq     = (state_q == FETCH);
    assign outIcSeg     = pstate0_q[15:0];
    assign outIcOfs     = pstate1_q;
    assign outFdValid   = (state_q == VALID);
    assign outFdPstate0 = pstate0_q;
    assign outFdPstate1 = pstate1_q;
    assign outFdInstr   = instr_q;
    assign outFdTrap    = trap_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage
// Directed vector table, a hand-written back-to-back sequence, then random
// traffic checked against a transaction-level reference model.
module tb_instr_fetch_stage;

    localparam int unsigned W  = 32;
    localparam int unsigned TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] inPstate0 = '0;
    logic [W-1:0] inPstate1 = '0;
    logic         inStall = 1'b0;
    logic         inFlush = 1'b0;
    logic         outAdrReady;
    logic         outIcReq;
    logic [15:0]  outIcSeg;
    logic [W-1:0] outIcOfs;
    logic         inIcAck = 1'b0;
    logic         inIcErr = 1'b0;
    logic [W-1:0] inIcData = '0;
    logic         outFdValid;
    logic [W-1:0] outFdPstate0;
    logic [W-1:0] outFdPstate1;
    logic [W-1:0] outFdInstr;
    logic [1:0]   outFdTrap;

    always #5 clk = ~clk;

    instr_fetch_stage #(.WORD_LENGTH(W), .FETCH_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .inPstate0(inPstate0), .inPstate1(inPstate1),
        .inStall(inStall), .inFlush(inFlush),
        .outAdrReady(outAdrReady),
        .outIcReq(outIcReq), .outIcSeg(outIcSeg), .outIcOfs(outIcOfs),
        .inIcAck(inIcAck), .inIcErr(inIcErr), .inIcData(inIcData),
        .outFdValid(outFdValid),
        .outFdPstate0(outFdPstate0), .outFdPstate1(outFdPstate1),
        .outFdInstr(outFdInstr), .outFdTrap(outFdTrap)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic s, input logic a,
                         input logic e, input logic [31:0] p0, input logic [31:0] p1,
                         input logic [31:0] d);
        rst = r; inFlush = f; inStall = s; inIcAck = a; inIcErr = e;
        inPstate0 = p0; inPstate1 = p1; inIcData = d;
    endtask

    // One table row = inputs applied for one cycle + outputs expected in that cycle.
    typedef struct {
        logic        rst, flush, stall, ack, err;
        logic [31:0] p1, data;
        logic        e_ready, e_req, e_valid;
        logic [1:0]  e_trap;
        logic [31:0] e_instr, e_p1;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic s, input logic a,
                                input logic e, input logic [31:0] p1, input logic [31:0] d,
                                input logic er, input logic eq, input logic ev,
                                input logic [1:0] et, input logic [31:0] ei,
                                input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.flush = f; v.stall = s; v.ack = a; v.err = e;
        v.p1 = p1; v.data = d;
        v.e_ready = er; v.e_req = eq; v.e_valid = ev;
        v.e_trap = et; v.e_instr = ei; v.e_p1 = ep;
        return v;
    endfunction

    // Reference model: one outstanding fetch, one result slot.
    bit          m_pend, m_have, m_rstk;
    int          m_wait;
    logic [31:0] m_p0, m_p1, m_instr;
    logic [1:0]  m_trap;

    function automatic bit m_ready();
        return !rst && !inFlush && ((!m_pend && !m_have) || (m_have && !inStall));
    endfunction

    task automatic m_reset();
        m_pend = 0; m_have = 0; m_rstk = 1; m_wait = 0;
        m_p0 = 0; m_p1 = 0; m_instr = 0; m_trap = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic m_step();
        if (rst) begin
            m_reset();
        end else if (inFlush) begin
            m_pend = 0; m_have = 0;
        end else if (m_ready()) begin
            m_p0 = inPstate0; m_p1 = inPstate1; m_rstk = 0;
            if (inPstate1[1:0] != 2'b00) begin
                m_pend = 0; m_have = 1; m_trap = 2; m_instr = 0;
            end else begin
                m_pend = 1; m_have = 0; m_wait = 0;
            end
        end else if (m_pend) begin
            if (inIcAck) begin
                m_pend = 0; m_have = 1;
                m_trap  = inIcErr ? 2'd1 : 2'd0;
                m_instr = inIcErr ? 32'h0 : inIcData;
            end else if (m_wait == int'(TO)) begin
                m_pend = 0; m_have = 1; m_trap = 3; m_instr = 0;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic check_model();
        chk("rnd_ready", 32'(outAdrReady), 32'(m_ready()));
        chk("rnd_req",   32'(outIcReq),    32'(m_pend));
        chk("rnd_valid", 32'(outFdValid),  32'(m_have));
        chk("rnd_seg",   32'(outIcSeg),    32'(m_p0[15:0]));
        chk("rnd_ofs",   outIcOfs,         m_p1);
        chk("rnd_p0",    outFdPstate0,     m_p0);
        chk("rnd_p1",    outFdPstate1,     m_p1);
        if (m_have || m_rstk) begin
            chk("rnd_instr", outFdInstr,      m_instr);
            chk("rnd_trap",  32'(outFdTrap),  32'(m_trap));
        end
    endtask

    vec_t tbl[28];

    initial begin
        logic [31:0] p1r;
        logic [31:0] seg = 32'h0000_ABCD;

        //                r  f  s  a  e  p1             data           rdy req val trap instr          p1exp
        tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 2'd0, 32'h0,         32'h0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 32'h0000_1000, 32'h0,         1, 0, 0, 2'd0, 32'h0,         32'h0);
        tbl[2]  = mk(0, 0, 0, 1, 0, 32'h0000_1000, 32'hDEAD_BEEF, 0, 1, 0, 2'd0, 32'h0,         32'h0000_1000);
        tbl[3]  = mk(0, 0, 1, 0, 0, 32'h0000_2000, 32'h0,         0, 0, 1, 2'd0, 32'hDEAD_BEEF, 32'h0000_1000);
        tbl[4]  = mk(0, 0, 1, 0, 0, 32'h0000_2000, 32'h0,         0, 0, 1, 2'd0, 32'hDEAD_BEEF, 32'h0000_1000);
        tbl[5]  = mk(0, 0, 1, 0, 0, 32'h0000_2000, 32'h0,         0, 0, 1, 2'd0, 32'hDEAD_BEEF, 32'h0000_1000);
        tbl[6]  = mk(0, 0, 0, 0, 0, 32'h0000_2000, 32'h0,         1, 0, 1, 2'd0, 32'hDEAD_BEEF, 32'h0000_1000);
        tbl[7]  = mk(0, 0, 0, 0, 0, 32'h0000_2000, 32'h0,         0, 1, 0, 2'd0, 32'h0,         32'h0000_2000);
        tbl[8]  = mk(0, 0, 0, 1, 1, 32'h0000_2000, 32'h1234_5678, 0, 1, 0, 2'd0, 32'h0,         32'h0000_2000);
        tbl[9]  = mk(0, 0, 0, 0, 0, 32'h0000_1002, 32'h0,         1, 0, 1, 2'd1, 32'h0,         32'h0000_2000);
        tbl[10] = mk(0, 0, 0, 0, 0, 32'h0000_3000, 32'h0,         1, 0, 1, 2'd2, 32'h0,         32'h0000_1002);
        tbl[11] = mk(0, 1, 0, 1, 0, 32'h0000_3000, 32'hCAFE_F00D, 0, 1, 0, 2'd0, 32'h0,         32'h0000_3000);
        tbl[12] = mk(0, 0, 0, 0, 0, 32'h0000_4000, 32'h0,         1, 0, 0, 2'd0, 32'h0,         32'h0000_3000);
        for (int i = 13; i <= 17; i++)
            tbl[i] = mk(0, 0, 0, 0, 0, 32'h0000_4000, 32'h0,      0, 1, 0, 2'd0, 32'h0,         32'h0000_4000);
        tbl[18] = mk(0, 0, 1, 0, 0, 32'h0000_5000, 32'h0,         0, 0, 1, 2'd3, 32'h0,         32'h0000_4000);
        tbl[19] = mk(0, 0, 0, 0, 0, 32'h0000_5000, 32'h0,         1, 0, 1, 2'd3, 32'h0,         32'h0000_4000);
        tbl[20] = mk(1, 0, 0, 0, 0, 32'h0000_5000, 32'h0,         0, 1, 0, 2'd0, 32'h0,         32'h0000_5000);
        tbl[21] = mk(0, 1, 0, 1, 0, 32'h0000_5000, 32'h0,         0, 0, 0, 2'd0, 32'h0,         32'h0);
        tbl[22] = mk(0, 0, 0, 1, 0, 32'h0000_6000, 32'h1111_1111, 1, 0, 0, 2'd0, 32'h0,         32'h0);
        tbl[23] = mk(0, 0, 0, 0, 0, 32'h0000_6000, 32'h0,         0, 1, 0, 2'd0, 32'h0,         32'h0000_6000);
        tbl[24] = mk(0, 0, 0, 1, 0, 32'h0000_6000, 32'h0BAD_F00D, 0, 1, 0, 2'd0, 32'h0,         32'h0000_6000);
        tbl[25] = mk(0, 0, 1, 0, 0, 32'h0000_7000, 32'h0,         0, 0, 1, 2'd0, 32'h0BAD_F00D, 32'h0000_6000);
        tbl[26] = mk(0, 0, 1, 1, 0, 32'h0000_7000, 32'h2222_2222, 0, 0, 1, 2'd0, 32'h0BAD_F00D, 32'h0000_6000);
        tbl[27] = mk(0, 1, 1, 0, 0, 32'h0000_7000, 32'h0,         0, 0, 1, 2'd0, 32'h0BAD_F00D, 32'h0000_6000);

        // Initial reset.
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].rst, tbl[i].flush, tbl[i].stall, tbl[i].ack, tbl[i].err,
                  seg, tbl[i].p1, tbl[i].data);
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(outAdrReady), 32'(tbl[i].e_ready));
            chk($sformatf("vec%0d_req",   i), 32'(outIcReq),    32'(tbl[i].e_req));
            chk($sformatf("vec%0d_valid", i), 32'(outFdValid),  32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_p1",    i), outFdPstate1,     tbl[i].e_p1);
            chk($sformatf("vec%0d_ofs",   i), outIcOfs,         tbl[i].e_p1);
            if (tbl[i].e_valid || i == 0 || i == 21) begin
                chk($sformatf("vec%0d_instr", i), outFdInstr,     tbl[i].e_instr);
                chk($sformatf("vec%0d_trap",  i), 32'(outFdTrap), 32'(tbl[i].e_trap));
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Back-to-back fetches with immediate acks (stage is IDLE here).
        drive(0, 0, 0, 0, 0, 32'h0000_0042, 32'h0000_0100, 32'h0);
        #1 chk("b2b_ready0", 32'(outAdrReady), 32'd1);
        @(posedge clk); @(negedge clk);
        drive(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0000_00A1);
        #1 chk("b2b_req0", 32'(outIcReq), 32'd1);
        chk("b2b_seg0", 32'(outIcSeg), 32'h0000_0042);
        @(posedge clk); @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0000_0043, 32'h0000_0104, 32'h0);
        #1 chk("b2b_valid1", 32'(outFdValid), 32'd1);
        chk("b2b_instr1", outFdInstr, 32'h0000_00A1);
        chk("b2b_ready1", 32'(outAdrReady), 32'd1);
        @(posedge clk); @(negedge clk);
        drive(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0000_00A2);
        #1 chk("b2b_req2", 32'(outIcReq), 32'd1);
        chk("b2b_ofs2", outIcOfs, 32'h0000_0104);
        chk("b2b_valid2", 32'(outFdValid), 32'd0);
        @(posedge clk); @(negedge clk);
        drive(0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
        #1 chk("b2b_instr3", outFdInstr, 32'h0000_00A2);
        chk("b2b_p0_3", outFdPstate0, 32'h0000_0043);
        chk("b2b_trap3", 32'(outFdTrap), 32'd0);
        @(posedge clk); @(negedge clk);

        // Random traffic against the model.
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        @(posedge clk); @(negedge clk);
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            p1r = $urandom();
            if ($urandom_range(0, 4) != 0) p1r[1:0] = 2'b00;
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  $urandom(), p1r, $urandom());
            #1 check_model();
            @(posedge clk);
            m_step();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
